// File: rtl/proc_ctrl.sv
// rtl/proc_ctrl.sv - command sequencer driving iteration beats into the accumulate datapath
module proc_ctrl #(
    parameter int unsigned PIPE_LAT = 4
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic [3:0]  proc_cmd,
    input  logic [31:0] niter,
    input  logic        dp_ready,
    output logic        dp_valid,
    output logic [31:0] dp_iter,
    output logic        dp_clr,
    output logic [3:0]  proc_status,
    output logic [31:0] proc_cycles
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] CMD_START = 4'h1;
    localparam logic [3:0] CMD_ABORT = 4'h2;
    localparam logic [3:0] CMD_CLEAR = 4'h3;
    localparam logic [7:0] DRAIN_LOAD = 8'(PIPE_LAT);

    state_t      state;
    state_t      state_n;
    logic [3:0]  cmd_d;
    logic [31:0] remaining;
    logic [7:0]  drain_cnt;
    logic        aborted;
    logic        aborted_n;
    logic        err;
    logic        err_n;
    logic        cyc_clear;
    logic        start_ev;
    logic        abort_ev;
    logic        clear_ev;
    logic        xfer;
    logic        busy;
    logic        busy_n;
    logic        done;

    // A command fires only on the cycle its value first appears on the level input.
    assign start_ev = (proc_cmd == CMD_START) && (cmd_d != CMD_START);
    assign abort_ev = (proc_cmd == CMD_ABORT) && (cmd_d != CMD_ABORT);
    assign clear_ev = (proc_cmd == CMD_CLEAR) && (cmd_d != CMD_CLEAR);

    // An abort on the same edge as an accepted beat wins, so that beat is not counted.
    assign xfer   = (state == S_RUN) && dp_valid && dp_ready && !abort_ev;
    assign busy   = (state == S_CLR) || (state == S_RUN) || (state == S_DRAIN);
    assign busy_n = (state_n == S_CLR) || (state_n == S_RUN) || (state_n == S_DRAIN);

    // Previous command value used for edge detection.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            cmd_d <= 4'h0;
        end else begin
            cmd_d <= proc_cmd;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode plus sticky flag and cycle-counter clear decisions.
    always_comb begin
        state_n   = state;
        aborted_n = aborted;
        err_n     = err;
        cyc_clear = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_ev) begin
                    aborted_n = 1'b0;
                    if (niter == 32'd0) begin
                        err_n   = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        err_n     = 1'b0;
                        cyc_clear = 1'b1;
                        state_n   = S_CLR;
                    end
                end else if (clear_ev) begin
                    aborted_n = 1'b0;
                    err_n     = 1'b0;
                    state_n   = S_IDLE;
                end
            end
            S_CLR: begin
                if (abort_ev) begin
                    aborted_n = 1'b1;
                    state_n   = S_IDLE;
                end else begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (abort_ev) begin
                    aborted_n = 1'b1;
                    state_n   = S_IDLE;
                end else if (xfer && (remaining == 32'd1)) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort_ev) begin
                    aborted_n = 1'b1;
                    state_n   = S_IDLE;
                end else if (drain_cnt == 8'd0) begin
                    state_n = S_DONE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Beat index, remaining count and drain countdown.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            remaining <= 32'd0;
            dp_iter   <= 32'd0;
            drain_cnt <= 8'd0;
        end else begin
            if (state == S_CLR) begin
                remaining <= niter;
                dp_iter   <= 32'd0;
            end else if (xfer) begin
                remaining <= remaining - 32'd1;
                dp_iter   <= dp_iter + 32'd1;
                if (remaining == 32'd1) begin
                    drain_cnt <= DRAIN_LOAD;
                end
            end
            if ((state == S_DRAIN) && (drain_cnt != 8'd0)) begin
                drain_cnt <= drain_cnt - 8'd1;
            end
        end
    end

    // Registered handshake, clear pulse and status bits, all derived from the next state.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            dp_valid <= 1'b0;
            dp_clr   <= 1'b0;
            aborted  <= 1'b0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            dp_valid <= (state_n == S_RUN);
            dp_clr   <= (state_n == S_CLR);
            aborted  <= aborted_n;
            err      <= err_n;
            done     <= (state_n == S_DONE);
        end
    end

    // Busy flag as seen by the host.
    logic busy_q;
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_n;
        end
    end

    assign proc_status = {err, aborted, done, busy_q};

    // Elapsed busy cycles: restarted by an accepted START, saturating, frozen while idle.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            proc_cycles <= 32'd0;
        end else if (cyc_clear) begin
            proc_cycles <= 32'd0;
        end else if (busy && (proc_cycles != 32'hFFFF_FFFF)) begin
            proc_cycles <= proc_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_proc_ctrl.sv
// tb/tb_proc_ctrl.sv - directed self-checking bench for proc_ctrl
module tb_proc_ctrl;

    logic        clk = 1'b0;
    logic        nRESET;
    logic [3:0]  proc_cmd;
    logic [31:0] niter;
    logic        dp_ready;
    logic        dp_valid;
    logic [31:0] dp_iter;
    logic        dp_clr;
    logic [3:0]  proc_status;
    logic [31:0] proc_cycles;

    int checks = 0;
    int failures = 0;
    int xfers = 0;
    int clrs = 0;
    int base_x;
    int base_c;
    int n;

    proc_ctrl #(.PIPE_LAT(2)) dut (
        .clk(clk),
        .nRESET(nRESET),
        .proc_cmd(proc_cmd),
        .niter(niter),
        .dp_ready(dp_ready),
        .dp_valid(dp_valid),
        .dp_iter(dp_iter),
        .dp_clr(dp_clr),
        .proc_status(proc_status),
        .proc_cycles(proc_cycles)
    );

    always #5 clk = ~clk;

    // Count handshakes and clear pulses as the datapath would see them.
    always @(posedge clk) begin
        if (nRESET) begin
            if (dp_valid && dp_ready) xfers++;
            if (dp_clr) clrs++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!proc_status[1] && cnt < 200);
    endtask

    initial begin
        nRESET   = 1'b0;
        proc_cmd = 4'h0;
        niter    = 32'd0;
        dp_ready = 1'b0;
        #12;
        check("rst_valid", dp_valid, 0);
        check("rst_iter", dp_iter, 0);
        check("rst_clr", dp_clr, 0);
        check("rst_status", proc_status, 0);
        check("rst_cycles", proc_cycles, 0);
        @(negedge clk);
        nRESET = 1'b1;
        tick();
        tick();

        // Basic run with a START->NOP->START glitch while running.
        niter = 3; dp_ready = 1'b1; proc_cmd = 4'h1;
        base_x = xfers; base_c = clrs;
        tick();
        check("b_clr_k", dp_clr, 1);
        check("b_status_k", proc_status, 4'b0001);
        check("b_valid_k", dp_valid, 0);
        tick();
        check("b_clr_k1", dp_clr, 0);
        check("b_valid_k1", dp_valid, 1);
        check("b_iter_k1", dp_iter, 0);
        proc_cmd = 4'h0;
        tick();
        check("b_iter_k2", dp_iter, 1);
        proc_cmd = 4'h1;
        tick();
        check("b_iter_k3", dp_iter, 2);
        tick();
        check("b_iter_k4", dp_iter, 3);
        check("b_valid_k4", dp_valid, 0);
        check("b_status_k4", proc_status, 4'b0001);
        tick();
        tick();
        check("b_status_k6", proc_status, 4'b0001);
        tick();
        check("b_status_k7", proc_status, 4'b0010);
        check("b_cycles", proc_cycles, 7);
        check("b_xfers", xfers - base_x, 3);
        check("b_clrs", clrs - base_c, 1);
        proc_cmd = 4'h0;
        tick();

        // Stall run; START then held 50 cycles.
        niter = 4; proc_cmd = 4'h1;
        base_x = xfers; base_c = clrs;
        tick();
        check("s_clr", dp_clr, 1);
        tick();
        check("s_iter0", dp_iter, 0);
        tick();
        check("s_iter1", dp_iter, 1);
        dp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s_hold_iter", dp_iter, 1);
            check("s_hold_valid", dp_valid, 1);
        end
        dp_ready = 1'b1;
        wait_done(n);
        check("s_done_edge", n, 6);
        check("s_cycles", proc_cycles, 13);
        repeat (36) tick();
        check("s_held_status", proc_status, 4'b0010);
        check("s_xfers", xfers - base_x, 4);
        check("s_clrs", clrs - base_c, 1);
        proc_cmd = 4'h0;
        tick();

        // Abort after two transfers.
        niter = 5; proc_cmd = 4'h1;
        tick();
        tick();
        tick();
        tick();
        check("a_iter2", dp_iter, 2);
        proc_cmd = 4'h2;
        tick();
        check("a_valid", dp_valid, 0);
        check("a_iter_nocount", dp_iter, 2);
        check("a_status", proc_status, 4'b0100);
        check("a_cycles", proc_cycles, 4);
        repeat (5) tick();
        check("a_held_status", proc_status, 4'b0100);
        check("a_held_valid", dp_valid, 0);

        // Zero iteration count, then CLEAR.
        niter = 0; proc_cmd = 4'h1;
        base_x = xfers; base_c = clrs;
        tick();
        check("z_status", proc_status, 4'b1000);
        check("z_cycles", proc_cycles, 4);
        tick();
        tick();
        check("z_clrs", clrs - base_c, 0);
        check("z_xfers", xfers - base_x, 0);
        check("z_status2", proc_status, 4'b1000);
        proc_cmd = 4'h3;
        tick();
        check("z_cleared", proc_status, 4'b0000);

        // Asynchronous reset in DRAIN, then restart from held START.
        niter = 2; proc_cmd = 4'h1;
        tick();
        check("r_status_clr", proc_status, 4'b0001);
        tick();
        tick();
        tick();
        check("r_valid_drain", dp_valid, 0);
        check("r_status_drain", proc_status, 4'b0001);
        #2;
        nRESET = 1'b0;
        #1;
        check("r_valid", dp_valid, 0);
        check("r_iter", dp_iter, 0);
        check("r_clr", dp_clr, 0);
        check("r_status", proc_status, 0);
        check("r_cycles", proc_cycles, 0);
        @(negedge clk);
        nRESET = 1'b1;
        tick();
        check("r_restart_clr", dp_clr, 1);
        check("r_restart_status", proc_status, 4'b0001);
        wait_done(n);
        check("r_done_edge", n, 6);
        check("r_done_cycles", proc_cycles, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
